table_packer: RTL and testbench

- Write-side counterpart of the 4x4 byte table buffer.
- Collects a stream of bytes, such as convolution output pixels, through a valid/ready handshake and places them in row-major order.
- Once the table is complete, presents it as one 128-bit word on a valid/ready output for the memory writer.
- The packing matches the table buffer's load format: element [0][0] occupies bits [127:120] and element [3][3] occupies bits [7:0].

---
 rtl/table_packer.sv | 115 +++++++++++
 tb/tb_table_packer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/table_packer.sv
// Collects ROWS*COLS elements in row-major order and emits them as one packed word.
// Optional partial-table flush port enabled by defining TABLE_PACKER_FLUSH_EN.
module table_packer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr,
`ifdef TABLE_PACKER_FLUSH_EN
    input  logic                             flush,
`endif
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ROWS*COLS*DATA_W-1:0]      out_data,
    output logic [$clog2(ROWS*COLS):0]       fill_cnt
);

    localparam int unsigned N     = ROWS * COLS;
    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [DATA_W-1:0]  elem_q [N];
    logic [DATA_W-1:0]  elem_d [N];

    // State, count and element registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
            for (int i = 0; i < N; i++) begin
                elem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            for (int i = 0; i < N; i++) begin
                elem_q[i] <= elem_d[i];
            end
        end
    end

    // Next-state: clr dominates; FILL writes at fill_cnt, FULL waits for the output handshake
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        for (int i = 0; i < N; i++) begin
            elem_d[i] = elem_q[i];
        end

        if (clr) begin
            state_d    = FILL;
            fill_cnt_d = '0;
            for (int i = 0; i < N; i++) begin
                elem_d[i] = '0;
            end
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        elem_d[fill_cnt_q[IDX_W-1:0]] = in_data;
                        fill_cnt_d = fill_cnt_q + CNT_W'(1);
                        if (fill_cnt_q == CNT_W'(N - 1)) begin
                            state_d = FULL;
                        end
                    end
`ifdef TABLE_PACKER_FLUSH_EN
                    // Partial table: pad the unwritten tail with zeros, keep the count
                    if (flush && (fill_cnt_d != '0)) begin
                        state_d = FULL;
                        for (int i = 0; i < N; i++) begin
                            if (CNT_W'(i) >= fill_cnt_d) begin
                                elem_d[i] = '0;
                            end
                        end
                    end
`endif
                end
                FULL: begin
                    if (out_ready) begin
                        state_d    = FILL;
                        fill_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    // Element 0 lands in the most significant byte
    always_comb begin
        out_data = '0;
        for (int i = 0; i < N; i++) begin
            out_data[(N - 1 - i) * DATA_W +: DATA_W] = elem_q[i];
        end
    end

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == FULL);
    assign fill_cnt  = fill_cnt_q;

endmodule

// File: tb/tb_table_packer.sv
// Directed bench for table_packer; flush case compiled when TABLE_PACKER_FLUSH_EN is defined.
module tb_table_packer;

    logic         clk;
    logic         rst;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [4:0]   fill_cnt;
`ifdef TABLE_PACKER_FLUSH_EN
    logic         flush;
`endif

    int vectors;
    int miscompares;

    table_packer dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
`ifdef TABLE_PACKER_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .fill_cnt  (fill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [127:0] held;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
`ifdef TABLE_PACKER_FLUSH_EN
        flush     = 1'b0;
`endif

        // Reset state
        #12;
        chk("rst_fill_cnt",  128'(fill_cnt),  128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data",  out_data,        128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready",  128'(in_ready),  128'd1);

        // Stream 0x00..0x0F back to back
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
            if (i == 14) begin
                chk("stream_cnt15",   128'(fill_cnt),  128'd15);
                chk("stream_valid15", 128'(out_valid), 128'd0);
            end
        end
        chk("full_out_valid", 128'(out_valid), 128'd1);
        chk("full_out_data",  out_data, 128'h000102030405060708090A0B0C0D0E0F);
        chk("full_fill_cnt",  128'(fill_cnt),  128'd16);
        chk("full_in_ready",  128'(in_ready),  128'd0);

        // Backpressure: input ignored while FULL
        held     = 128'h000102030405060708090A0B0C0D0E0F;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_data", out_data, held);
            chk("hold_cnt",  128'(fill_cnt), 128'd16);
        end
        out_ready = 1'b1;
        step();
        chk("oacc_valid", 128'(out_valid), 128'd0);
        chk("oacc_cnt",   128'(fill_cnt),  128'd0);
        chk("oacc_ready", 128'(in_ready),  128'd1);
        out_ready = 1'b0;
        step();
        chk("refill_cnt", 128'(fill_cnt),        128'd1);
        chk("refill_msb", 128'(out_data[127:120]), 128'hAA);

        clr      = 1'b1;
        in_valid = 1'b0;
        step();
        clr = 1'b0;
        chk("clr1_cnt",  128'(fill_cnt), 128'd0);
        chk("clr1_data", out_data,       128'd0);

        // Gapped input, out_ready high in FILL has no effect
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 8'h11 + 8'(i / 2);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("gap_cnt",   128'(fill_cnt),  128'd7);
        chk("gap_valid", 128'(out_valid), 128'd0);
        chk("gap_data",  out_data, 128'h11121314151617000000000000000000);

        // clr beats a simultaneous input accept
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        step();
        clr = 1'b0;
        chk("clr2_cnt",  128'(fill_cnt), 128'd0);
        chk("clr2_data", out_data,       128'd0);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h20 + 8'(i);
            step();
        end
        in_valid = 1'b0;
        chk("t2_valid", 128'(out_valid), 128'd1);
        chk("t2_data",  out_data, 128'h202122232425262728292A2B2C2D2E2F);

        // clr with out_ready on a pending table
        clr       = 1'b1;
        out_ready = 1'b1;
        step();
        clr       = 1'b0;
        out_ready = 1'b0;
        chk("drop_valid", 128'(out_valid), 128'd0);
        chk("drop_cnt",   128'(fill_cnt),  128'd0);
        chk("drop_data",  out_data,        128'd0);

        // Asynchronous reset between edges
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h50 + 8'(i);
            step();
        end
        in_valid = 1'b0;
        chk("pre_arst_cnt", 128'(fill_cnt), 128'd10);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cnt",   128'(fill_cnt),  128'd0);
        chk("arst_valid", 128'(out_valid), 128'd0);
        chk("arst_data",  out_data,        128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;

`ifdef TABLE_PACKER_FLUSH_EN
        // Partial flush with a same-cycle accept
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hC1 + 8'(i);
            step();
        end
        in_data = 8'hC4;
        flush   = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 128'(out_valid), 128'd1);
        chk("flush_cnt",   128'(fill_cnt),  128'd4);
        chk("flush_data",  out_data, 128'hC1C2C3C4000000000000000000000000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
